// File: rtl/tt_pll_pkg.sv
// Shared types and constants for the PLL phase/frequency detector.
package tt_pll_pkg;

  localparam int PHASE_ERR_W = 8;
  localparam int LOCK_CNT_W  = 5;
  localparam int SCAN_LEN    = 15;

  localparam logic [PHASE_ERR_W-1:0] WIDTH_MAX = 8'd127;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } pfd_state_t;

  function automatic logic [PHASE_ERR_W-1:0] abs_err(input logic signed [PHASE_ERR_W-1:0] e);
    return e[PHASE_ERR_W-1] ? PHASE_ERR_W'(-e) : PHASE_ERR_W'(e);
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_pfd.sv
// Sampled phase/frequency detector: measures ref/fb edge spacing in i_clk_gen
// cycles, drives up/down pulses and tracks lock; state is on a 15-bit scan chain.
//
//   state | meaning
//   IDLE  | waiting for the first edge of a comparison
//   UP    | ref edge seen, waiting for fb edge (ref leads)
//   DOWN  | fb edge seen, waiting for ref edge (fb leads)
module tt_pfd
  import tt_pll_pkg::*;
#(
  parameter int LOCK_WIN   = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic                          i_clk_gen,
  input  logic                          i_rst_n,
  input  logic                          i_ref,
  input  logic                          i_fb,
  input  logic                          i_enable,
  output logic                          o_up,
  output logic                          o_down,
  output logic signed [PHASE_ERR_W-1:0] o_phase_err,
  output logic                          o_phase_valid,
  output logic                          o_locked,
  input  logic                          i_scan_en,
  input  logic                          i_scan_in,
  output logic                          o_scan_out
);

  localparam logic [PHASE_ERR_W-1:0] WIN  = PHASE_ERR_W'(LOCK_WIN);
  localparam logic [LOCK_CNT_W-1:0]  LCNT = LOCK_CNT_W'(LOCK_COUNT);

  logic ref_sync, fb_sync, ref_prev, fb_prev;
  logic ref_rise, fb_rise;

  logic [1:0]                   state_q, state_d;
  logic [PHASE_ERR_W-1:0]       width_q, width_d, width_inc;
  logic [LOCK_CNT_W-1:0]        lock_q, lock_d;
  logic signed [PHASE_ERR_W-1:0] cmp_err;
  logic                         complete;

  tt_sync2 u_sync_ref (.clk(i_clk_gen), .rst_n(i_rst_n), .d(i_ref), .q(ref_sync));
  tt_sync2 u_sync_fb  (.clk(i_clk_gen), .rst_n(i_rst_n), .d(i_fb),  .q(fb_sync));

  // Previous samples run unconditionally so re-enable or scan exit never fakes an edge.
  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ref_prev <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      ref_prev <= ref_sync;
      fb_prev  <= fb_sync;
    end
  end

  assign ref_rise  = ref_sync & ~ref_prev;
  assign fb_rise   = fb_sync & ~fb_prev;
  assign width_inc = (width_q == WIDTH_MAX) ? WIDTH_MAX : width_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    lock_d   = lock_q;
    cmp_err  = '0;
    complete = 1'b0;
    if (i_scan_en) begin
      state_d = {state_q[0], i_scan_in};
      width_d = {width_q[PHASE_ERR_W-2:0], state_q[1]};
      lock_d  = {lock_q[LOCK_CNT_W-2:0], width_q[PHASE_ERR_W-1]};
    end else if (!i_enable) begin
      state_d = IDLE;
      width_d = '0;
      lock_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise && !fb_rise) begin
            state_d = UP;
            width_d = '0;
          end else if (fb_rise && !ref_rise) begin
            state_d = DOWN;
            width_d = '0;
          end else if (ref_rise && fb_rise) begin
            complete = 1'b1;
          end
        end
        UP: begin
          // width_inc includes the completing cycle, so it equals the o_up high time.
          width_d = width_inc;
          if (fb_rise) begin
            state_d  = IDLE;
            complete = 1'b1;
            cmp_err  = $signed(width_inc);
          end
        end
        DOWN: begin
          width_d = width_inc;
          if (ref_rise) begin
            state_d  = IDLE;
            complete = 1'b1;
            cmp_err  = -$signed(width_inc);
          end
        end
        default: state_d = IDLE;
      endcase
      if (complete) begin
        if (abs_err(cmp_err) <= WIN)
          lock_d = (lock_q == LCNT) ? lock_q : lock_q + 5'd1;
        else
          lock_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      width_q       <= '0;
      lock_q        <= '0;
      o_phase_err   <= '0;
      o_phase_valid <= 1'b0;
      o_locked      <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      lock_q        <= lock_d;
      o_phase_valid <= complete;
      o_locked      <= (lock_d == LCNT);
      if (complete) o_phase_err <= cmp_err;
    end
  end

  assign o_up       = (state_q == UP);
  assign o_down     = (state_q == DOWN);
  assign o_scan_out = lock_q[LOCK_CNT_W-1];

endmodule
